// File: rtl/ppm_modulator.sv
// M-ary pulse-position modulator: one frame of 2**SYM_BITS pulse slots plus guard slots per
// accepted symbol, with seamless back-to-back frames and start/done/underrun status pulses.
module ppm_modulator #(
  parameter int unsigned SYM_BITS    = 2,
  parameter int unsigned SLOT_CYCLES = 16,
  parameter int unsigned GUARD_SLOTS = 4,
  parameter bit          IDLE_LEVEL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sym_valid,
  input  logic [SYM_BITS-1:0] sym_data,
  output logic                sym_ready,
  output logic                ppm,
  output logic                busy,
  output logic                sym_start,
  output logic                sym_done,
  output logic                underrun
);

  localparam int unsigned M            = 1 << SYM_BITS;
  localparam int unsigned NSLOTS       = M + GUARD_SLOTS;
  localparam int unsigned FRAME_CYCLES = NSLOTS * SLOT_CYCLES;
  localparam int unsigned CW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned SW           = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IW           = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  localparam logic [CW-1:0] CntLast  = CW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0] SlotLast = SW'(SLOT_CYCLES - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]       slot_idx_q, slot_idx_d;
  logic [SYM_BITS-1:0] sym_q, sym_d;
  logic                accept, frame_last, underrun_d, pulse_d;

  assign frame_last = (state_q == StSend) && (cnt_q == CntLast);
  assign sym_ready  = (state_q == StIdle) || frame_last;
  assign accept     = sym_valid && sym_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_cnt_d = slot_cnt_q;
    slot_idx_d = slot_idx_q;
    sym_d      = sym_q;
    underrun_d = 1'b0;
    if (accept) begin
      // Covers both a fresh start from idle and a seamless reload on the last cycle.
      state_d    = StSend;
      cnt_d      = '0;
      slot_cnt_d = '0;
      slot_idx_d = '0;
      sym_d      = sym_data;
    end else if (frame_last) begin
      state_d    = StIdle;
      cnt_d      = '0;
      slot_cnt_d = '0;
      slot_idx_d = '0;
      underrun_d = 1'b1;
    end else if (state_q == StSend) begin
      cnt_d = cnt_q + CW'(1);
      if (slot_cnt_q == SlotLast) begin
        slot_cnt_d = '0;
        slot_idx_d = slot_idx_q + IW'(1);
      end else begin
        slot_cnt_d = slot_cnt_q + SW'(1);
      end
    end
  end

  // Guard slot indices are >= M so they can never match a symbol.
  assign pulse_d = (state_d == StSend) && (slot_idx_d == IW'(sym_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      slot_cnt_q <= '0;
      slot_idx_q <= '0;
      sym_q      <= '0;
      ppm        <= IDLE_LEVEL;
      busy       <= 1'b0;
      sym_start  <= 1'b0;
      sym_done   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_cnt_q <= slot_cnt_d;
      slot_idx_q <= slot_idx_d;
      sym_q      <= sym_d;
      ppm        <= pulse_d ? ~IDLE_LEVEL : IDLE_LEVEL;
      busy       <= (state_d == StSend);
      sym_start  <= (state_d == StSend) && (cnt_d == '0);
      sym_done   <= (state_d == StSend) && (cnt_d == CntLast);
      underrun   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_ppm_modulator.sv
// Directed bench for ppm_modulator: default build plus a 3-bit, 1-cycle-slot, no-guard build.
module tb_ppm_modulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       sym_valid = 1'b0;
  logic [1:0] sym_data = 2'd0;
  logic       sym_ready, ppm, busy, sym_start, sym_done, underrun;

  logic       v2 = 1'b0;
  logic [2:0] d2 = 3'd0;
  logic       rdy2, p2, b2, st2, dn2, ur2;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ppm_modulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_ready (sym_ready),
    .ppm       (ppm),
    .busy      (busy),
    .sym_start (sym_start),
    .sym_done  (sym_done),
    .underrun  (underrun)
  );

  ppm_modulator #(
    .SYM_BITS    (3),
    .SLOT_CYCLES (1),
    .GUARD_SLOTS (0),
    .IDLE_LEVEL  (1'b0)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (v2),
    .sym_data  (d2),
    .sym_ready (rdy2),
    .ppm       (p2),
    .busy      (b2),
    .sym_start (st2),
    .sym_done  (dn2),
    .underrun  (ur2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called at the negedge of frame cycle 0; returns at the negedge after frame cycle 127.
  // Counts per-cycle mismatches against the expected frame of symbol s.
  task automatic frame(input int s, input bit nv, input int ns, output int errs);
    logic exp_ppm;
    errs = 0;
    for (int f = 0; f < 128; f++) begin
      exp_ppm = ((f / 16) == s) ? 1'b0 : 1'b1;
      if (ppm !== exp_ppm) errs++;
      if (busy !== 1'b1) errs++;
      if (sym_start !== (f == 0)) errs++;
      if (sym_done !== (f == 127)) errs++;
      if (sym_ready !== (f == 127)) errs++;
      if (underrun !== 1'b0) errs++;
      if (f == 127) begin
        sym_valid = nv;
        sym_data  = 2'(ns);
      end else if (!sym_valid) begin
        sym_data = sym_data ^ 2'(f + 1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int   errs;
    logic exp_p;

    repeat (3) @(negedge clk);
    check("rst_ppm", ppm, 1);
    check("rst_busy", busy, 0);
    check("rst_flags", {sym_start, sym_done, underrun}, 0);
    check("rst_ready", sym_ready, 1);
    check("rst_ppm2", p2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ppm", ppm, 1);
    check("idle_busy", busy, 0);

    // Single symbol 2 with sym_data toggling while not valid
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    @(negedge clk);
    sym_valid = 1'b0;
    frame(2, 1'b0, 0, errs);
    check("single_frame", errs, 0);
    check("single_underrun", underrun, 1);
    check("single_after_busy", busy, 0);
    check("single_after_ppm", ppm, 1);
    check("single_after_ready", sym_ready, 1);
    @(negedge clk);
    check("underrun_one_cycle", underrun, 0);

    // Back-to-back 0,3,1,2
    sym_valid = 1'b1;
    sym_data  = 2'd0;
    @(negedge clk);
    frame(0, 1'b1, 3, errs);
    check("stream_f0", errs, 0);
    frame(3, 1'b1, 1, errs);
    check("stream_f1", errs, 0);
    frame(1, 1'b1, 2, errs);
    check("stream_f2", errs, 0);
    frame(2, 1'b0, 0, errs);
    check("stream_f3", errs, 0);
    check("stream_underrun", underrun, 1);
    check("stream_end_busy", busy, 0);

    // Late valid: raised in the underrun cycle, next frame 2 cycles after sym_done
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = 2'd1;
    @(negedge clk);
    sym_valid = 1'b0;
    frame(1, 1'b0, 0, errs);
    check("late_first", errs, 0);
    check("late_underrun", underrun, 1);
    check("late_idle_ready", sym_ready, 1);
    sym_valid = 1'b1;
    sym_data  = 2'd3;
    @(negedge clk);
    sym_valid = 1'b0;
    check("late_start", sym_start, 1);
    frame(3, 1'b0, 0, errs);
    check("late_second", errs, 0);
    check("late_underrun2", underrun, 1);

    // Asynchronous reset mid-pulse
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = 2'd2;
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_pulse", ppm, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ppm", ppm, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {busy, sym_done, underrun}, 0);
    check("post_rst_ready", sym_ready, 1);
    sym_valid = 1'b1;
    sym_data  = 2'd0;
    @(negedge clk);
    sym_valid = 1'b0;
    frame(0, 1'b0, 0, errs);
    check("post_rst_frame", errs, 0);
    check("post_rst_underrun", underrun, 1);

    // Small build: stream 7 then 0, pulses on adjacent cycles 7 and 8
    v2 = 1'b1;
    d2 = 3'd7;
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      exp_p = (i == 7) || (i == 8);
      if (p2 !== exp_p) errs++;
      if (b2 !== 1'b1) errs++;
      if (st2 !== ((i % 8) == 0)) errs++;
      if (dn2 !== ((i % 8) == 7)) errs++;
      if (rdy2 !== ((i % 8) == 7)) errs++;
      if (ur2 !== 1'b0) errs++;
      if (i == 7) d2 = 3'd0;
      if (i == 8) v2 = 1'b0;
      @(negedge clk);
    end
    check("small_stream", errs, 0);
    check("small_underrun", ur2, 1);
    check("small_idle_ppm", p2, 0);
    check("small_idle_busy", b2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
